// File: rtl/mux_scan_receiver.sv
// Scan controller and receiver for a remote 4:1 mux: steps the select lines,
// samples mux_out at the end of each slot and publishes complete 4-bit frames.
module mux_scan_receiver #(
    parameter int unsigned SLOT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       mux_out,
    output logic [1:0] select,
    output logic [3:0] data_out,
    output logic       frame_valid,
    output logic [9:0] LED
);

    localparam int unsigned CNT_W = $clog2(SLOT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       select_q, select_d;
    logic [2:0]       shadow_q, shadow_d;
    logic [3:0]       data_q, data_d;
    logic             frame_valid_q, frame_valid_d;

    always_comb begin
        cnt_d         = cnt_q;
        select_d      = select_q;
        shadow_d      = shadow_q;
        data_d        = data_q;
        frame_valid_d = 1'b0;
        if (enable) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                select_d = select_q + 2'd1;
                // Slots 0..2 land in the shadow; slot 3 commits the whole frame at once.
                case (select_q)
                    2'd0: shadow_d[0] = mux_out;
                    2'd1: shadow_d[1] = mux_out;
                    2'd2: shadow_d[2] = mux_out;
                    default: begin
                        data_d        = {mux_out, shadow_q};
                        frame_valid_d = 1'b1;
                    end
                endcase
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            select_q      <= '0;
            shadow_q      <= '0;
            data_q        <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            select_q      <= select_d;
            shadow_q      <= shadow_d;
            data_q        <= data_d;
            frame_valid_q <= frame_valid_d;
        end
    end

    assign select      = select_q;
    assign data_out    = data_q;
    assign frame_valid = frame_valid_q;
    assign LED         = {select_q, frame_valid_q, mux_out, 2'b00, data_q};

endmodule

// File: tb/tb_mux_scan_receiver.sv
// Directed self-checking bench for mux_scan_receiver (SLOT_CYCLES=4 and 2).
module tb_mux_scan_receiver;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enable = 1'b0;
    logic       tog_mode = 1'b0;
    logic       tog = 1'b0;
    logic [3:0] in_vec = 4'b0000;
    logic [3:0] in2 = 4'b0000;

    logic       mux_out, mux_out2;
    logic [1:0] select, select2;
    logic [3:0] data_out, data_out2;
    logic       frame_valid, frame_valid2;
    logic [9:0] led, led2;

    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    // Behavioural remote muxes
    assign mux_out  = tog_mode ? tog : in_vec[select];
    assign mux_out2 = in2[select2];

    mux_scan_receiver #(.SLOT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .enable(enable), .mux_out(mux_out),
        .select(select), .data_out(data_out), .frame_valid(frame_valid), .LED(led)
    );

    mux_scan_receiver #(.SLOT_CYCLES(2)) dut2 (
        .clk(clk), .reset(reset), .enable(enable), .mux_out(mux_out2),
        .select(select2), .data_out(data_out2), .frame_valid(frame_valid2), .LED(led2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int unsigned cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        reset = 1'b0;
    endtask

    initial begin
        // 1: reset with mux_out toggling
        tog_mode = 1'b1;
        enable   = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tog = ~tog;
            tick();
            check("rst_select", 32'(select), 32'd0);
            check("rst_data", 32'(data_out), 32'd0);
            check("rst_fv", 32'(frame_valid), 32'd0);
            check("rst_led_hi", 32'(led[9:7]), 32'd0);
            check("rst_led_lo", 32'(led[3:0]), 32'd0);
            check("rst_led_mux", 32'(led[6]), 32'(tog));
        end
        reset    = 1'b0;
        tog_mode = 1'b0;

        // 2: basic frame, in=1010
        in_vec = 4'b1010;
        do_reset(1);
        for (int n = 1; n <= 32; n++) begin
            tick();
            check("basic_select", 32'(select), 32'((n / 4) % 4));
            check("basic_fv", 32'(frame_valid), 32'(n % 16 == 0));
            if (n == 15) check("basic_data_pre", 32'(data_out), 32'd0);
            if (n == 16) begin
                check("basic_data", 32'(data_out), 32'b1010);
                check("basic_led", 32'(led), 32'b00_1_0_00_1010);
            end
            if (n == 20) check("basic_data_hold", 32'(data_out), 32'b1010);
        end

        // 3: input change at start of slot 2
        in_vec = 4'b0000;
        do_reset(1);
        repeat (8) tick();
        check("chg_select2", 32'(select), 32'd2);
        in_vec = 4'b1111;
        repeat (8) tick();
        check("chg_fv1", 32'(frame_valid), 32'd1);
        check("chg_data1", 32'(data_out), 32'b1100);
        repeat (16) tick();
        check("chg_fv2", 32'(frame_valid), 32'd1);
        check("chg_data2", 32'(data_out), 32'b1111);

        // 4: pause 10 cycles during slot 1
        in_vec = 4'b1010;
        do_reset(1);
        repeat (4) tick();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_vec = (i % 2 == 0) ? 4'b0101 : 4'b1010;
            tick();
            check("pause_select", 32'(select), 32'd1);
            check("pause_fv", 32'(frame_valid), 32'd0);
        end
        in_vec = 4'b1010;
        enable = 1'b1;
        repeat (11) tick();
        check("pause_fv_early", 32'(frame_valid), 32'd0);
        tick();
        check("pause_fv", 32'(frame_valid), 32'd1);
        check("pause_data", 32'(data_out), 32'b1010);

        // 4b: enable dropped exactly on the would-be sample edge
        do_reset(1);
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check("edge_nosample", 32'(select), 32'd0);
        enable = 1'b1;
        tick();
        check("edge_resume", 32'(select), 32'd1);

        // 5: reset mid-frame
        in_vec = 4'b1010;
        do_reset(1);
        repeat (16) tick();
        check("midrst_pre", 32'(data_out), 32'b1010);
        in_vec = 4'b0110;
        repeat (8) tick();
        check("midrst_sel2", 32'(select), 32'd2);
        do_reset(1);
        check("midrst_data", 32'(data_out), 32'd0);
        check("midrst_select", 32'(select), 32'd0);
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("midrst_fv", 32'(frame_valid), 32'(n == 16));
            if (n == 15) check("midrst_data0", 32'(data_out), 32'd0);
        end
        check("midrst_data_new", 32'(data_out), 32'b0110);

        // 6: minimum slot length
        in2 = 4'b0101;
        do_reset(1);
        for (int n = 1; n <= 16; n++) begin
            tick();
            check("min_select", 32'(select2), 32'((n / 2) % 4));
            check("min_fv", 32'(frame_valid2), 32'(n % 8 == 0));
            if (n == 8 || n == 16) check("min_data", 32'(data_out2), 32'b0101);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_scan_receiver.md
Name: mux_scan_receiver

Overview:
Controller and receiver at the far end of the 4:1 multiplexer. It drives the mux select lines, samples the single mux output once per slot, and rebuilds the four original inputs as a parallel word. It cycles through select 0..3 continuously and publishes one full 4-bit frame per sweep. A board-level LED map is provided for the DE-series bring-up flow.

Parameters:
SLOT_CYCLES, 4, clock cycles each select value is held (legal range 2..255); the sample is taken on the last cycle of the slot to allow mux settling.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
enable  input  1  scan enable; low freezes all sequencing state
mux_out  input  1  output of the remote 4:1 mux (the currently selected input)
select  output  2  select lines driven to the remote mux, registered
data_out  output  4  reconstructed inputs; bit n = mux_out sampled while select==n
frame_valid  output  1  one-cycle pulse when data_out is updated
LED  output  10  board LEDs: [3:0]=data_out, [6]=mux_out, [7]=frame_valid, [9:8]=select, [5:4]=0

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high; every register clears on the rising clk edge where reset=1.
- Reset values: select=0, data_out=0, frame_valid=0, internal cycle counter=0, shadow register[2:0]=0. LED follows these values (LED[6] follows mux_out combinationally).
- Cycle counter width is ceil(log2(SLOT_CYCLES)) bits and counts 0..SLOT_CYCLES-1 while enable=1.
- Sample point is the edge where enable=1 and the counter is at SLOT_CYCLES-1. At that edge:
  - if select<3: shadow[select] <= mux_out;
  - if select==3: data_out <= {mux_out, shadow[2:0]} and frame_valid <= 1;
  - the counter goes to 0;
  - select goes to select+1 and wraps from 3 to 0.
- frame_valid is high only in the cycle immediately after a slot-3 sample, and low in every other cycle.
- Frame period is 4*SLOT_CYCLES cycles with enable held high. The first frame_valid after reset is asserted on cycle 4*SLOT_CYCLES, counting the first post-reset edge as cycle 1.
- data_out holds its value between frames. Shadow bits are not visible until the slot-3 commit, so data_out never shows a partial frame.
- enable=0: counter, select, shadow and data_out hold, and frame_valid is 0. Raising enable again resumes from the frozen counter and select; the partial frame is kept, not restarted.
- enable falling in the same cycle as a would-be sample: the sample does not happen.
- reset mid-frame: the partial frame is discarded, all state goes to its reset value, and the next frame starts at select=0. reset has priority over enable.
- mux_out changing mid-slot is ignored; only the value at the sample edge matters.
- No combinational path from mux_out to select, data_out or frame_valid.

Test Plan:
1. Reset check, SLOT_CYCLES=4: assert reset for 3 cycles with mux_out toggling -> select=0, data_out=0, frame_valid=0, LED[9:7]=0 and LED[3:0]=0 throughout.
2. Basic frame: behavioural mux with in=4'b1010, enable=1 after reset -> select steps 0,1,2,3 every 4 cycles; on cycle 16, data_out=4'b1010 and frame_valid=1 for exactly one cycle; the next pulse is on cycle 32.
3. Input change mid-frame: in=4'b0000 until select==2 (held 4 cycles), then in=4'b1111 -> first frame data_out=4'b1100, second frame data_out=4'b1111.
4. Pause: drop enable for 10 cycles while select==1 -> select stays 1, frame_valid stays 0, and the frame completes 10 cycles later than in scenario 2 with the same data_out=4'b1010.
5. Reset mid-frame: pulse reset at select==2 with in=4'b0110 -> data_out=0 with no frame_valid; the next frame yields data_out=4'b0110, 16 cycles after reset deasserts.
6. Minimum slot, SLOT_CYCLES=2: in=4'b0101 -> select changes every 2 cycles, data_out=4'b0101, frame_valid period is 8 cycles.
